// File: rtl/nr4sdm_pkg.sv
// Shared types and constants for the NR4SD- serial decoder.
package nr4sdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef logic signed [2:0] digit_t;

    // Modified-Booth magnitude codes, packed as {two, one}
    localparam logic [1:0] MB_ZERO    = 2'b00;
    localparam logic [1:0] MB_ONE     = 2'b01;
    localparam logic [1:0] MB_TWO     = 2'b10;
    localparam logic [1:0] MB_ILLEGAL = 2'b11;

    localparam digit_t DIG_ZERO  = 3'sb000;
    localparam digit_t DIG_POS1  = 3'sb001;
    localparam digit_t DIG_POS2  = 3'sb010;
    localparam digit_t DIG_NEG1  = 3'sb111;
    localparam digit_t DIG_NEG2  = 3'sb110;

endpackage

// File: rtl/nr4sdm_digit_value.sv
// Value of one recoded radix-4 digit: NR4SD- pair or the top Modified-Booth digit.
module nr4sdm_digit_value
    import nr4sdm_pkg::*;
(
    input  logic   mb_sel,
    input  logic   nm,
    input  logic   np,
    input  logic   sign,
    input  logic   one,
    input  logic   two,
    output digit_t digit,
    output logic   illegal
);

    always_comb begin
        digit   = DIG_ZERO;
        illegal = 1'b0;
        if (mb_sel) begin
            case ({two, one})
                MB_ZERO: digit = DIG_ZERO;
                MB_ONE:  digit = sign ? DIG_NEG1 : DIG_POS1;
                MB_TWO:  digit = sign ? DIG_NEG2 : DIG_POS2;
                default: begin
                    // one & two together is not a valid code; contribute nothing
                    digit   = DIG_ZERO;
                    illegal = 1'b1;
                end
            endcase
        end else begin
            case ({nm, np})
                2'b00:   digit = DIG_ZERO;
                2'b01:   digit = DIG_POS1;
                2'b10:   digit = DIG_NEG2;
                default: digit = DIG_NEG1;
            endcase
        end
    end

endmodule

// File: rtl/nr4sdm_serial_decoder.sv
// Serial NR4SD- to two's-complement decoder: one radix-4 digit per clock, MSB first (Horner).
module nr4sdm_serial_decoder
    import nr4sdm_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH/2-2:0]     nm,
    input  logic [WIDTH/2-2:0]     np,
    input  logic                   sign,
    input  logic                   one,
    input  logic                   two,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       result,
    output logic                   err
);

    localparam int unsigned NRD = WIDTH / 2 - 1;
    localparam int unsigned AW  = WIDTH + 2;
    localparam int unsigned CW  = $clog2(WIDTH / 2 + 1);
    localparam int unsigned IW  = (NRD > 1) ? $clog2(NRD) : 1;

    localparam logic [CW-1:0] NRD_C  = CW'(NRD);
    localparam logic [CW-1:0] LAST_C = CW'(WIDTH / 2);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  acc;
    logic [NRD-1:0]        nm_q;
    logic [NRD-1:0]        np_q;
    logic                  sign_q;
    logic                  one_q;
    logic                  two_q;

    logic [IW-1:0]         sel_idx;
    logic [NRD-1:0]        sel_mask;
    logic                  dv_mb_sel;
    logic                  dv_nm;
    logic                  dv_np;
    logic                  dv_sign;
    logic                  dv_one;
    logic                  dv_two;
    digit_t                dv_digit;
    logic                  dv_illegal;

    // Step k (k >= 1) consumes NR4SD- digit NRD-k; step 0 the top MB digit
    assign sel_idx  = IW'(NRD_C - cnt);
    assign sel_mask = NRD'(1) << sel_idx;

    // In IDLE the evaluator sees the live top digit so the illegal flag is ready at accept
    always_comb begin
        dv_mb_sel = 1'b1;
        dv_nm     = 1'b0;
        dv_np     = 1'b0;
        dv_sign   = sign;
        dv_one    = one;
        dv_two    = two;
        if (state == ST_DECODE) begin
            dv_mb_sel = (cnt == '0);
            dv_nm     = |(nm_q & sel_mask);
            dv_np     = |(np_q & sel_mask);
            dv_sign   = sign_q;
            dv_one    = one_q;
            dv_two    = two_q;
        end
    end

    nr4sdm_digit_value u_digit_value (
        .mb_sel  (dv_mb_sel),
        .nm      (dv_nm),
        .np      (dv_np),
        .sign    (dv_sign),
        .one     (dv_one),
        .two     (dv_two),
        .digit   (dv_digit),
        .illegal (dv_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            nm_q      <= '0;
            np_q      <= '0;
            sign_q    <= 1'b0;
            one_q     <= 1'b0;
            two_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        nm_q     <= nm;
                        np_q     <= np;
                        sign_q   <= sign;
                        one_q    <= one;
                        two_q    <= two;
                        err      <= dv_illegal;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cnt == LAST_C) begin
                        result    <= acc[WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        acc <= (acc << 2) + {{(AW-3){dv_digit[2]}}, dv_digit};
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nr4sdm_serial_decoder.sv
// Directed bench for nr4sdm_serial_decoder: round trips, raw codes, backpressure, reset abort.
module tb_nr4sdm_serial_decoder;

    localparam int unsigned W   = 16;
    localparam int unsigned NRD = W / 2 - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [NRD-1:0] nm;
    logic [NRD-1:0] np;
    logic           sign;
    logic           one;
    logic           two;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic           err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nr4sdm_serial_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .nm        (nm),
        .np        (np),
        .sign      (sign),
        .one       (one),
        .two       (two),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference NR4SD- encoder: lower digits in {-2,-1,0,1}, remainder is the MB top digit
    task automatic encode(input logic [W-1:0] a);
        int x;
        int r;
        int d;
        x = int'($signed(a));
        for (int j = 0; j < int'(NRD); j++) begin
            r = x & 3;
            case (r)
                0:       d = 0;
                1:       d = 1;
                2:       d = -2;
                default: d = -1;
            endcase
            nm[j] = (d < 0);
            np[j] = (d == 1) || (d == -1);
            x = (x - d) >>> 2;
        end
        sign = (x < 0);
        one  = (x == 1) || (x == -1);
        two  = (x == 2) || (x == -2);
    endtask

    task automatic drive_raw(input logic [NRD-1:0] n_m, input logic [NRD-1:0] n_p,
                             input logic s, input logic o, input logic t);
        nm = n_m; np = n_p; sign = s; one = o; two = t;
    endtask

    // Wait for out_valid after the accepting edge; returns edges counted
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Present the word on the inputs, handshake, decode, then drain with out_ready
    task automatic run_word(input string tag, input logic [W-1:0] exp_res, input logic exp_err);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        nm = ~nm; np = ~np; sign = ~sign; one = 1'b1; two = 1'b1;
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drained"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic [W-1:0] vec [6];
        logic [W-1:0] held_res;
        logic         held_err;
        int           lat;
        bit           pre_ready;
        vec[0] = 16'h0000; vec[1] = 16'h0001; vec[2] = 16'h7FFF;
        vec[3] = 16'h8000; vec[4] = 16'hFFFF; vec[5] = 16'h1234;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_raw('0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            encode(vec[i]);
            run_word($sformatf("rt_%04h", vec[i]), vec[i], 1'b0);
        end

        drive_raw(7'h00, 7'h01, 1'b0, 1'b0, 1'b0);
        run_word("raw_np1", 16'h0001, 1'b0);
        drive_raw(7'h00, 7'h00, 1'b1, 1'b0, 1'b1);
        run_word("raw_neg2top", 16'h8000, 1'b0);
        drive_raw(7'h00, 7'h00, 1'b1, 1'b0, 1'b0);
        run_word("raw_negzero", 16'h0000, 1'b0);
        drive_raw(7'h00, 7'h03, 1'b0, 1'b1, 1'b1);
        run_word("illegal_mb", 16'h0005, 1'b1);

        // Backpressure: result held, second word waits until one cycle after out_ready
        encode(16'h1234);
        in_valid = 1'b1;
        @(posedge clk); #1;
        encode(16'h00FF);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd9);
        held_res = result;
        held_err = err;
        check("bp_first_result", 32'(held_res), 32'h1234);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_result", 32'(result), 32'(held_res));
            check("bp_hold_err", 32'(err), 32'(held_err));
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        pre_ready = in_ready;
        check("bp_idle_after_ready", 32'({out_valid, pre_ready}), 32'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'd9);
        check("bp_second_result", 32'(result), 32'h00FF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the 4th DECODE cycle aborts the word
        encode(16'h4321);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("abort_busy", 32'(in_ready), 32'd0);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_no_output", 32'(out_valid), 32'd0);
        encode(16'h00FF);
        run_word("post_rst_00ff", 16'h00FF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
